// File: rtl/axi_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the two-master AXI-lite read arbiter.
//   arb_state_e : FSM state (IDLE / ADDR / DATA)
//   RESP_*      : single-bit read response encoding
//   M_IFU/M_LSU : master indices (also the encoding of grant and rr_ptr)
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_rr_picker2.sv
// ---------------------------------------------------------------------------
// rr_picker2
// Combinational two-way picker.
//   req    : request vector, bit i = master i
//   rr_ptr : index of the master favoured on a tie (round-robin mode)
//   fixed  : 1 = master 0 always wins a tie, rr_ptr ignored
//   gnt    : one-hot winner (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_picker2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       fixed,
  output logic [1:0] gnt
);

  logic favoured;

  assign favoured = fixed ? M_IFU : rr_ptr;

  // A master wins if it is alone, or if both request and it is favoured.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pick
      assign gnt[gi] = req[gi] && (!req[1-gi] || (favoured == 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
// Two-master (m0 = IFU, m1 = LSU) to one-slave AXI-lite read arbiter, one
// outstanding read at a time.
//   clk, rst               : clock, synchronous active-high reset
//   m{0,1}_ar*             : master read-address channels (arready pulsed
//                            in IDLE for the winner)
//   m{0,1}_r*              : master read-data channels (routed from slave
//                            only to the granted master)
//   s_ar*                  : slave read-address channel (address registered)
//   s_r*                   : slave read-data channel
// FIXED_PRIO = 0 gives round-robin on ties, 1 makes master 0 always win.
// ---------------------------------------------------------------------------
module axi_rd_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready
);

  arb_state_e        state_reg;
  logic              grant_reg;
  logic              rr_ptr_reg;
  logic [ADDR_W-1:0] s_araddr_reg;
  logic              s_arvalid_reg;

  logic [1:0]        req;
  logic [1:0]        pick_gnt;
  logic              pick_idx;
  logic [ADDR_W-1:0] pick_addr;
  logic              idle_phase;
  logic              data_phase;

  logic [1:0]        arready_vec;
  logic [1:0]        rready_vec;
  logic [1:0]        rvalid_vec;
  logic [1:0]        rresp_vec;
  logic [DATA_W-1:0] rdata_arr [2];

  assign req        = {m1_arvalid, m0_arvalid};
  assign rready_vec = {m1_rready, m0_rready};

  rr_picker2 u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .fixed  (FIXED_PRIO != 0),
    .gnt    (pick_gnt)
  );

  assign pick_idx  = pick_gnt[1] ? M_LSU : M_IFU;
  assign pick_addr = pick_gnt[1] ? m1_araddr : m0_araddr;

  // Handshake outputs are masked while rst is high so nothing completes in
  // the cycle that is being discarded.
  assign idle_phase = (state_reg == IDLE) && !rst;
  assign data_phase = (state_reg == DATA) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= M_IFU;
      rr_ptr_reg    <= M_IFU;
      s_araddr_reg  <= '0;
      s_arvalid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_reg     <= pick_idx;
            s_araddr_reg  <= pick_addr;
            s_arvalid_reg <= 1'b1;
            state_reg     <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) begin
            s_arvalid_reg <= 1'b0;
            state_reg     <= DATA;
          end
        end
        DATA: begin
          // grant is deliberately held; only the tie-break pointer moves.
          if (s_rvalid && s_rready) begin
            rr_ptr_reg <= ~grant_reg;
            state_reg  <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          s_arvalid_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      logic sel;
      assign sel             = data_phase && (grant_reg == 1'(gi));
      assign arready_vec[gi] = idle_phase && pick_gnt[gi];
      assign rvalid_vec[gi]  = sel && s_rvalid;
      assign rresp_vec[gi]   = sel ? s_rresp : RESP_OKAY;
      assign rdata_arr[gi]   = sel ? s_rdata : '0;
    end
  endgenerate

  assign m0_arready = arready_vec[0];
  assign m1_arready = arready_vec[1];
  assign m0_rvalid  = rvalid_vec[0];
  assign m1_rvalid  = rvalid_vec[1];
  assign m0_rresp   = rresp_vec[0];
  assign m1_rresp   = rresp_vec[1];
  assign m0_rdata   = rdata_arr[0];
  assign m1_rdata   = rdata_arr[1];

  assign s_araddr  = s_araddr_reg;
  assign s_arvalid = s_arvalid_reg;
  assign s_rready  = data_phase && rready_vec[grant_reg];

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Directed bench for axi_rd_arbiter: a round-robin instance driven cycle by
// cycle, plus a fixed-priority instance fed by an always-ready slave.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rst;

  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arvalid, m1_arvalid;
  logic        m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rresp, m1_rresp;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_rready, m1_rready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  logic        fp_req;
  logic        fp_m0_arready, fp_m1_arready;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_m0_rresp, fp_m1_rresp;
  logic        fp_m0_rvalid, fp_m1_rvalid;
  logic [31:0] fp_s_araddr;
  logic        fp_s_arvalid;
  logic        fp_s_rready;

  int n_tests;
  int n_fail;
  int hs_cnt;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_araddr  (m0_araddr),
    .m0_arvalid (m0_arvalid),
    .m0_arready (m0_arready),
    .m0_rdata   (m0_rdata),
    .m0_rresp   (m0_rresp),
    .m0_rvalid  (m0_rvalid),
    .m0_rready  (m0_rready),
    .m1_araddr  (m1_araddr),
    .m1_arvalid (m1_arvalid),
    .m1_arready (m1_arready),
    .m1_rdata   (m1_rdata),
    .m1_rresp   (m1_rresp),
    .m1_rvalid  (m1_rvalid),
    .m1_rready  (m1_rready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready)
  );

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk        (clk),
    .rst        (rst),
    .m0_araddr  (32'h100),
    .m0_arvalid (fp_req),
    .m0_arready (fp_m0_arready),
    .m0_rdata   (fp_m0_rdata),
    .m0_rresp   (fp_m0_rresp),
    .m0_rvalid  (fp_m0_rvalid),
    .m0_rready  (1'b1),
    .m1_araddr  (32'h200),
    .m1_arvalid (fp_req),
    .m1_arready (fp_m1_arready),
    .m1_rdata   (fp_m1_rdata),
    .m1_rresp   (fp_m1_rresp),
    .m1_rvalid  (fp_m1_rvalid),
    .m1_rready  (1'b1),
    .s_araddr   (fp_s_araddr),
    .s_arvalid  (fp_s_arvalid),
    .s_arready  (1'b1),
    .s_rdata    (32'h0),
    .s_rresp    (1'b0),
    .s_rvalid   (1'b1),
    .s_rready   (fp_s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && s_rvalid && s_rready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IDLE cycle: the expected winner sees arready, the other does not.
  task automatic grant(input bit m, input bit drop, input string tag);
    @(negedge clk);
    chk({tag, ":arready0"}, m0_arready, m == 1'b0);
    chk({tag, ":arready1"}, m1_arready, m == 1'b1);
    chk({tag, ":idle_arvalid"}, s_arvalid, 1'b0);
    $display("[TB] %s: AR granted to m%0d", tag, m);
    step();
    if (drop) begin
      if (m) m1_arvalid = 1'b0;
      else   m0_arvalid = 1'b0;
    end
  endtask

  // ADDR and DATA phases of a granted read, with optional wait states.
  task automatic finish_txn(input bit m, input logic [31:0] addr, input int arw,
                            input int rw, input logic [31:0] data, input bit resp,
                            input string tag);
    s_arready = 1'b0;
    for (int i = 0; i < arw; i++) begin
      @(negedge clk);
      chk({tag, ":arwait_valid"}, s_arvalid, 1'b1);
      chk({tag, ":arwait_addr"}, s_araddr, addr);
      chk({tag, ":arwait_no_arready"}, {m1_arready, m0_arready}, 2'b00);
      step();
    end
    s_arready = 1'b1;
    @(negedge clk);
    chk({tag, ":ar_valid"}, s_arvalid, 1'b1);
    chk({tag, ":ar_addr"}, s_araddr, addr);
    chk({tag, ":ar_no_arready"}, {m1_arready, m0_arready}, 2'b00);
    chk({tag, ":ar_no_rready"}, s_rready, 1'b0);
    step();
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = data;
    s_rresp   = resp;
    if (rw > 0) begin
      if (m) m1_rready = 1'b0;
      else   m0_rready = 1'b0;
    end
    for (int i = 0; i < rw; i++) begin
      @(negedge clk);
      chk({tag, ":rwait_arvalid"}, s_arvalid, 1'b0);
      chk({tag, ":rwait_srready"}, s_rready, 1'b0);
      chk({tag, ":rwait_rvalid"}, m ? m1_rvalid : m0_rvalid, 1'b1);
      chk({tag, ":rwait_no_arready"}, {m1_arready, m0_arready}, 2'b00);
      step();
    end
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    @(negedge clk);
    chk({tag, ":r_arvalid"}, s_arvalid, 1'b0);
    chk({tag, ":r_srready"}, s_rready, 1'b1);
    chk({tag, ":r_rvalid"}, m ? m1_rvalid : m0_rvalid, 1'b1);
    chk({tag, ":r_rdata"}, m ? m1_rdata : m0_rdata, data);
    chk({tag, ":r_rresp"}, m ? m1_rresp : m0_rresp, resp);
    chk({tag, ":other_rvalid"}, m ? m0_rvalid : m1_rvalid, 1'b0);
    chk({tag, ":other_rdata"}, m ? m0_rdata : m1_rdata, 32'h0);
    chk({tag, ":other_rresp"}, m ? m0_rresp : m1_rresp, 1'b0);
    chk({tag, ":r_no_arready"}, {m1_arready, m0_arready}, 2'b00);
    $display("[TB] %s: m%0d read addr=0x%08h data=0x%08h resp=%0d", tag, m, addr, data, resp);
    step();
    s_rvalid = 1'b0;
    s_rdata  = 32'h0;
    s_rresp  = 1'b0;
  endtask

  initial begin
    int base;
    int fp_ar;
    int fp_m1;

    n_tests    = 0;
    n_fail     = 0;
    hs_cnt     = 0;
    rst        = 1'b1;
    fp_req     = 1'b0;
    m0_araddr  = 32'h0;
    m1_araddr  = 32'h0;
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    m0_rready  = 1'b1;
    m1_rready  = 1'b1;
    s_arready  = 1'b0;
    s_rdata    = 32'h0;
    s_rresp    = 1'b0;
    s_rvalid   = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst:s_arvalid", s_arvalid, 1'b0);
    chk("rst:s_araddr", s_araddr, 32'h0);
    chk("rst:s_rready", s_rready, 1'b0);
    chk("rst:arready", {m1_arready, m0_arready}, 2'b00);
    chk("rst:rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    chk("rst:rdata0", m0_rdata, 32'h0);
    chk("rst:rdata1", m1_rdata, 32'h0);
    $display("[TB] reset: outputs idle");
    step();

    // Single m0 read, 0-wait slave
    m0_araddr  = 32'h8000_0000;
    m0_arvalid = 1'b1;
    grant(1'b0, 1'b1, "single");
    finish_txn(1'b0, 32'h8000_0000, 0, 0, 32'hDEAD_BEEF, 1'b0, "single");
    @(negedge clk);
    chk("single:after_rvalid", m0_rvalid, 1'b0);
    chk("single:after_srready", s_rready, 1'b0);
    step();

    // m1 read with slave AR and master R backpressure
    m1_araddr  = 32'h0000_0300;
    m1_arvalid = 1'b1;
    base = hs_cnt;
    grant(1'b1, 1'b1, "bp");
    finish_txn(1'b1, 32'h0000_0300, 10, 5, 32'h1234_5678, 1'b0, "bp");
    chk("bp:r_handshakes", 64'(hs_cnt - base), 64'd1);

    // m1 arrives one cycle after m0 is granted; it then reads an error response
    m0_araddr  = 32'h0000_0040;
    m0_arvalid = 1'b1;
    grant(1'b0, 1'b1, "late");
    m1_araddr  = 32'h0000_0080;
    m1_arvalid = 1'b1;
    finish_txn(1'b0, 32'h0000_0040, 2, 1, 32'hCAFE_0001, 1'b0, "late");
    grant(1'b1, 1'b1, "late_m1");
    finish_txn(1'b1, 32'h0000_0080, 0, 0, 32'h0BAD_0002, 1'b1, "rresp_err");

    // Round robin with both masters requesting continuously
    m0_araddr  = 32'h100;
    m1_araddr  = 32'h200;
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      grant(1'(i % 2), 1'b0, "rr");
      finish_txn(1'(i % 2), (i % 2) ? 32'h200 : 32'h100, 0, 0, 32'(i + 1), 1'b0, "rr");
    end
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    step();

    // Reset while in DATA, late slave response afterwards
    m0_araddr  = 32'h0000_0500;
    m0_arvalid = 1'b1;
    grant(1'b0, 1'b1, "rstdata");
    s_arready = 1'b1;
    @(negedge clk);
    chk("rstdata:ar_valid", s_arvalid, 1'b1);
    step();
    s_arready = 1'b0;
    rst = 1'b1;
    step();
    rst      = 1'b0;
    s_rvalid = 1'b1;
    s_rdata  = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstdata:s_arvalid", s_arvalid, 1'b0);
      chk("rstdata:s_araddr", s_araddr, 32'h0);
      chk("rstdata:s_rready", s_rready, 1'b0);
      chk("rstdata:rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      chk("rstdata:rdata0", m0_rdata, 32'h0);
      step();
    end
    $display("[TB] rstdata: late slave response ignored");
    s_rvalid = 1'b0;
    s_rdata  = 32'h0;
    m0_araddr  = 32'h0000_0600;
    m0_arvalid = 1'b1;
    grant(1'b0, 1'b1, "post_rst");
    finish_txn(1'b0, 32'h0000_0600, 0, 0, 32'h5555_AAAA, 1'b0, "post_rst");

    // Fixed-priority instance: both request forever, m0 must always win
    fp_ar  = 0;
    fp_m1  = 0;
    fp_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fp_s_arvalid) begin
        fp_ar++;
        chk("fp:s_araddr", fp_s_araddr, 32'h100);
        $display("[TB] fp: slave AR addr=0x%08h", fp_s_araddr);
      end
      if (fp_m1_arready) fp_m1++;
      step();
    end
    fp_req = 1'b0;
    chk("fp:ar_count", 64'(fp_ar), 64'd4);
    chk("fp:m1_grants", 64'(fp_m1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Two-master to one-slave AXI-lite read-channel arbiter in front of the shared SRAM.
- Master 0: instruction fetch (IFU).
- Master 1: load path (LSU).
- Exactly one outstanding read at a time. Address is captured at grant; R channel is routed back to the granted master.
- Round-robin by default; fixed priority (m0 wins) selectable.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- FIXED_PRIO, 0; 1 = master 0 always wins when both request.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- m0_araddr  in  ADDR_W  master 0 read address
- m0_arvalid  in  1  master 0 address valid
- m0_arready  out  1  master 0 address accepted
- m0_rdata  out  DATA_W  master 0 read data
- m0_rresp  out  1  master 0 response (0 OKAY, 1 error)
- m0_rvalid  out  1  master 0 data valid
- m0_rready  in  1  master 0 data ready
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready: same as m0_*, for master 1
- s_araddr  out  ADDR_W  slave read address (registered)
- s_arvalid  out  1  slave address valid
- s_arready  in  1  slave address ready
- s_rdata  in  DATA_W  slave read data
- s_rresp  in  1  slave response
- s_rvalid  in  1  slave data valid
- s_rready  out  1  slave data ready

Behaviour:
- Single clock clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, grant=0, rr_ptr favours m0, s_araddr=0. Every valid/ready output (s_arvalid, s_rready, m*_arready, m*_rvalid) is 0. m*_rdata/m*_rresp are 0.
- States:
  - IDLE: no master selected.
  - ADDR: s_arvalid=1, s_araddr held.
  - DATA: waiting for the R handshake.
- IDLE:
  - If any m*_arvalid is high, the picker selects a winner.
  - Register: grant, s_araddr from the winner's araddr.
  - Pulse the winner's m*_arready for this one cycle, then move to ADDR.
  - The master's AR handshake completes in IDLE. The loser sees arready=0.
- ADDR:
  - s_arvalid=1, s_araddr stable.
  - On s_arvalid&&s_arready, move to DATA and drop s_arvalid.
  - No m*_arready is asserted in ADDR or DATA.
- DATA:
  - s_rready = granted m*_rready.
  - Granted m*_rvalid/rdata/rresp = slave values. The non-granted master sees rvalid=0 and rdata=0.
  - On s_rvalid&&s_rready, go to IDLE, update rr_ptr, and hold grant (unchanged).
- Picker:
  - Round-robin: on a tie, the master not served last wins. A lone requester always wins.
  - FIXED_PRIO=1: m0 wins every tie; rr_ptr is ignored.
- Latency:
  - Master AR accepted in cycle n; s_arvalid high in n+1.
  - Slave R handshake in cycle k; IDLE in k+1.
  - Earliest next grant is k+1. Minimum spacing between grants is 3 cycles with a 0-wait slave.
- Backpressure:
  - s_arready low holds ADDR indefinitely.
  - m*_rready low holds DATA. Slave rdata must stay stable (slave's AXI obligation).
- Master drops arvalid without a handshake: no grant is issued. Since arready is pulsed in IDLE, a drop after the arready pulse is a protocol error and undefined.
- rresp: passed through unmodified; the arbiter never generates errors.
- Reset mid-ADDR/DATA: the in-flight transaction is abandoned. The next cycle shows reset values. A late slave response after reset is ignored while in IDLE (s_rready=0).
- Simultaneous arvalid from both masters in IDLE: exactly one arready pulses. The other master stays pending and is granted first after completion (round-robin mode).

Decomposition:
- Package arb_pkg: state enum {IDLE, ADDR, DATA}, RESP_OKAY=1'b0, RESP_ERR=1'b1, master index constants M_IFU=0, M_LSU=1.
- Sub-module rr_picker2: combinational 2-way picker. Inputs req[1:0], rr_ptr, fixed. Output: one-hot gnt.
- FSM, address register and R mux live in the top level.

Test Plan:
- Single m0 read, araddr=0x8000_0000, 0-wait slave returns 0xDEAD_BEEF → m0_arready pulse at n; s_arvalid at n+1 with addr 0x8000_0000; m0_rdata=0xDEAD_BEEF, rresp=0; m1 sees no activity.
- Both masters request continuously, addresses 0x100 (m0) and 0x200 (m1), RR mode → slave address sequence 0x100, 0x200, 0x100, 0x200; with FIXED_PRIO=1 → 0x100 repeated.
- s_arready delayed 10 cycles and m1_rready delayed 5 cycles (delay blocks on the handshakes) → s_araddr stable across the wait; exactly one s_rvalid&&s_rready; data 0x1234_5678 reaches m1 only.
- Slave returns rresp=1 on m1 read → m1_rresp=1, m0_rresp=0, FSM back to IDLE next cycle.
- rst asserted in DATA, slave asserts s_rvalid after reset → all valids 0 cycle after rst; s_rready=0; no m*_rvalid; new m0 read after reset completes normally.
- m1 arvalid arrives one cycle after m0 is granted → m1 waits with arready=0 until m0's R handshake; m1 granted next IDLE cycle.
